// File: rtl/data_bus_arbiter.sv
// Two-master arbiter onto one shared data bus. At most one transaction is in
// flight: a request is forwarded (IDLE/HOLD), granted, and then the arbiter
// waits for the response or forces an error response after TIMEOUT cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no transaction; a winner is picked and forwarded combinationally
// HOLD     | forwarded request not yet granted; latched master kept on the bus
// WAIT_RSP | granted, waiting for s_rvalid_i or the timeout
module data_bus_arbiter #(
   parameter int          TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
   parameter bit          RR_EN    = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_gnt_o,
   output logic        m0_rvalid_o,
   output logic [31:0] m0_rdata_o,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_gnt_o,
   output logic        m1_rvalid_o,
   output logic [31:0] m1_rdata_o,
   output logic        s_req_o,
   output logic        s_we_o,
   output logic [3:0]  s_be_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_wdata_o,
   input  logic        s_gnt_i,
   input  logic        s_rvalid_i,
   input  logic [31:0] s_rdata_i,
   output logic        owner_o,
   output logic        timeout_o
);

   typedef enum logic [1:0] {IDLE, HOLD, WAIT_RSP} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        sel_q, sel_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        win;
   logic        fwd;
   logic        fwd_sel;
   logic        gnt;
   logic        rv;
   logic        tmo;
   logic [31:0] rd_val;

   // State and bookkeeping registers; reset makes m0 win the first tie
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         sel_q   <= 1'b0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic, winner selection and response routing
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      fwd     = 1'b0;
      fwd_sel = sel_q;
      gnt     = 1'b0;
      rv      = 1'b0;
      tmo     = 1'b0;
      rd_val  = 32'd0;

      // A tie goes to the master not granted last (or m0 in fixed priority);
      // otherwise the sole requester wins.
      if (m0_req_i && m1_req_i) begin
         win = RR_EN ? ~last_q : 1'b0;
      end else begin
         win = ~m0_req_i;
      end

      case (state_q)
         IDLE: begin
            if (m0_req_i || m1_req_i) begin
               fwd     = 1'b1;
               fwd_sel = win;
               if (!s_gnt_i) begin
                  sel_d   = win;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            fwd     = 1'b1;
            fwd_sel = sel_q;
         end
         WAIT_RSP: begin
            if (s_rvalid_i) begin
               rv      = 1'b1;
               rd_val  = s_rdata_i;
               state_d = IDLE;
            end else if (cnt_q == TMO_LAST) begin
               rv      = 1'b1;
               rd_val  = ERR_DATA;
               tmo     = 1'b1;
               state_d = IDLE;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (fwd && s_gnt_i) begin
         gnt     = 1'b1;
         owner_d = fwd_sel;
         last_d  = fwd_sel;
         cnt_d   = 8'd0;
         state_d = WAIT_RSP;
      end

      // Outputs are forced quiet for as long as reset is held.
      if (!rst_i) begin
         fwd = 1'b0;
         gnt = 1'b0;
         rv  = 1'b0;
         tmo = 1'b0;
      end
   end

   assign s_req_o   = fwd;
   assign s_we_o    = fwd & (fwd_sel ? m1_we_i : m0_we_i);
   assign s_be_o    = fwd ? (fwd_sel ? m1_be_i : m0_be_i) : 4'd0;
   assign s_addr_o  = fwd ? (fwd_sel ? m1_addr_i : m0_addr_i) : 32'd0;
   assign s_wdata_o = fwd ? (fwd_sel ? m1_wdata_i : m0_wdata_i) : 32'd0;

   assign m0_gnt_o    = gnt & ~fwd_sel;
   assign m1_gnt_o    = gnt & fwd_sel;
   assign m0_rvalid_o = rv & ~owner_q;
   assign m1_rvalid_o = rv & owner_q;
   assign m0_rdata_o  = (rv & ~owner_q) ? rd_val : 32'd0;
   assign m1_rdata_o  = (rv & owner_q) ? rd_val : 32'd0;

   assign owner_o   = owner_q;
   assign timeout_o = tmo;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of the arbitration rules.
module tb_data_bus_arbiter;
   localparam int          TO  = 16;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic clk_i = 1'b0;
   logic rst_i;
   logic m0_req, m0_we, m1_req, m1_we, s_gnt, s_rvalid;
   logic [3:0]  m0_be, m1_be;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;

   logic        m0_gnt, m0_rv, m1_gnt, m1_rv, s_req, s_we, owner, tmo;
   logic [31:0] m0_rd, m1_rd, s_addr, s_wdata;
   logic [3:0]  s_be;

   logic        fp_m0_gnt, fp_m0_rv, fp_m1_gnt, fp_m1_rv, fp_s_req, fp_s_we, fp_owner, fp_tmo;
   logic [31:0] fp_m0_rd, fp_m1_rd, fp_s_addr, fp_s_wdata;
   logic [3:0]  fp_s_be;

   // Expected values for the round-robin instance
   logic        e_sreq, e_we, e_gnt0, e_gnt1, e_rv0, e_rv1, e_owner, e_tmo;
   logic [3:0]  e_be;
   logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
   int          lastg;
   int          checks = 0;
   int          errs   = 0;

   always #5 clk_i = ~clk_i;

   data_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR), .RR_EN(1'b1)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
      .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rv), .m0_rdata_o(m0_rd),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
      .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rv), .m1_rdata_o(m1_rd),
      .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
      .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
      .owner_o(owner), .timeout_o(tmo)
   );

   data_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR), .RR_EN(1'b0)) dut_fp (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
      .m0_wdata_i(m0_wdata), .m0_gnt_o(fp_m0_gnt), .m0_rvalid_o(fp_m0_rv), .m0_rdata_o(fp_m0_rd),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
      .m1_wdata_i(m1_wdata), .m1_gnt_o(fp_m1_gnt), .m1_rvalid_o(fp_m1_rv), .m1_rdata_o(fp_m1_rd),
      .s_req_o(fp_s_req), .s_we_o(fp_s_we), .s_be_o(fp_s_be), .s_addr_o(fp_s_addr),
      .s_wdata_o(fp_s_wdata), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
      .owner_o(fp_owner), .timeout_o(fp_tmo)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, ":s_req"},   32'(s_req),   32'(e_sreq));
      chk({ph, ":s_we"},    32'(s_we),    32'(e_we));
      chk({ph, ":s_be"},    32'(s_be),    32'(e_be));
      chk({ph, ":s_addr"},  s_addr,       e_addr);
      chk({ph, ":s_wdata"}, s_wdata,      e_wdata);
      chk({ph, ":m0_gnt"},  32'(m0_gnt),  32'(e_gnt0));
      chk({ph, ":m1_gnt"},  32'(m1_gnt),  32'(e_gnt1));
      chk({ph, ":m0_rv"},   32'(m0_rv),   32'(e_rv0));
      chk({ph, ":m1_rv"},   32'(m1_rv),   32'(e_rv1));
      chk({ph, ":m0_rd"},   m0_rd,        e_rd0);
      chk({ph, ":m1_rd"},   m1_rd,        e_rd1);
      chk({ph, ":owner"},   32'(owner),   32'(e_owner));
      chk({ph, ":timeout"}, 32'(tmo),     32'(e_tmo));
   endtask

   task automatic clr_exp();
      e_sreq = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
      e_gnt0 = 0; e_gnt1 = 0; e_rv0 = 0; e_rv1 = 0; e_rd0 = 0; e_rd1 = 0; e_tmo = 0;
   endtask

   task automatic set_fwd(input int w);
      e_sreq  = 1;
      e_we    = (w == 0) ? m0_we    : m1_we;
      e_be    = (w == 0) ? m0_be    : m1_be;
      e_addr  = (w == 0) ? m0_addr  : m1_addr;
      e_wdata = (w == 0) ? m0_wdata : m1_wdata;
   endtask

   task automatic rand_payload();
      m0_we = 1'($urandom); m0_be = 4'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
      m1_we = 1'($urandom); m1_be = 4'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
   endtask

   // Round-robin rule: on a tie the master not granted last wins.
   function automatic int winner(input logic r0, input logic r1);
      if (r0 && r1) return (lastg == 0) ? 1 : 0;
      return r0 ? 0 : 1;
   endfunction

   // One transaction: h ungranted cycles, then grant; response on wait cycle rk
   // (rk > TO means the timeout fires first and the response arrives late).
   task automatic txn(input logic r0, input logic r1, input int h, input int rk,
                      input logic [31:0] rdata, input int raise_j, input bit keep,
                      input bit fp_chk);
      int w;
      bit done;
      m0_req = r0; m1_req = r1;
      w = winner(r0, r1);
      for (int j = 0; j <= h; j++) begin
         s_gnt    = (j == h);
         s_rvalid = 1'($urandom);
         s_rdata  = $urandom;
         if (j > 0 && j == raise_j) begin
            if (w == 0) m1_req = 1; else m0_req = 1;
         end
         clr_exp();
         set_fwd(w);
         if (j == h) begin
            if (w == 0) e_gnt0 = 1; else e_gnt1 = 1;
         end
         #2 check_all((j == h) ? "grant" : "hold");
         if (fp_chk && j == h) begin
            chk("fp_m0_gnt", 32'(fp_m0_gnt), 32'd1);
            chk("fp_m1_gnt", 32'(fp_m1_gnt), 32'd0);
         end
         @(posedge clk_i); #1;
      end
      lastg   = w;
      e_owner = w[0];
      s_gnt   = 0;
      if (!keep) begin m0_req = 0; m1_req = 0; end
      done = 0;
      for (int k = 1; k <= rk; k++) begin
         s_rvalid = (k == rk);
         s_rdata  = (k == rk) ? rdata : $urandom;
         clr_exp();
         if (!done) begin
            if (k == rk) begin
               if (w == 0) begin e_rv0 = 1; e_rd0 = rdata; end
               else        begin e_rv1 = 1; e_rd1 = rdata; end
               done = 1;
               if (!keep) begin m0_req = 1'($urandom); m1_req = 1'($urandom); end
            end else if (k == TO) begin
               if (w == 0) begin e_rv0 = 1; e_rd0 = ERR; end
               else        begin e_rv1 = 1; e_rd1 = ERR; end
               e_tmo = 1;
               done  = 1;
            end
         end
         #2 check_all(done && k > TO ? "late" : "wait");
         @(posedge clk_i); #1;
      end
      m0_req = 0; m1_req = 0; s_rvalid = 0;
   endtask

   initial begin
      int r, h, rk, sel;
      rst_i = 0;
      m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0; s_rdata = 0;
      rand_payload();
      lastg = 1; e_owner = 0;
      clr_exp();
      #1 check_all("reset");
      m0_req = 1; m1_req = 1; s_gnt = 1; s_rvalid = 1;
      #1 check_all("reset_busy");
      m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0;
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_i = 1;

      // Single m0 read with immediate grant and next-cycle response
      rand_payload();
      m0_addr = 32'h0000_0010; m0_we = 0;
      txn(1, 0, 0, 1, 32'h1234_5678, 9, 0, 0);

      // Held tie: round robin alternates, fixed priority always m0
      for (int t = 0; t < 4; t++) begin
         rand_payload();
         txn(1, 1, 0, 1, $urandom, 9, 1, 1);
      end

      // m1 held ungranted for 3 cycles while m0 rises in cycle 1
      rand_payload();
      txn(0, 1, 3, 2, $urandom, 1, 0, 0);

      // Timeout followed by a dropped late response
      rand_payload();
      txn(1, 0, 0, TO + 3, $urandom, 9, 0, 0);

      // Response coincident with the last timeout cycle
      rand_payload();
      txn(0, 1, 1, TO, 32'hCAFE_0001, 9, 0, 0);

      // Reset during WAIT_RSP after m0 was granted
      rand_payload();
      m0_req = 1; m1_req = 0; s_gnt = 1; s_rvalid = 0;
      clr_exp(); set_fwd(0); e_gnt0 = 1;
      #2 check_all("r_grant");
      @(posedge clk_i); #1;
      m0_req = 0; s_gnt = 0;
      #1 rst_i = 0;
      m0_req = 1; m1_req = 1; s_gnt = 1; s_rvalid = 1; s_rdata = $urandom;
      lastg = 1; e_owner = 0;
      clr_exp();
      #1 check_all("r_async");
      @(posedge clk_i); #1;
      check_all("r_held");
      m0_req = 0; m1_req = 0; s_gnt = 0;
      rst_i = 1;
      #2 check_all("r_rel");
      @(posedge clk_i); #1;
      #2 check_all("r_rel2");
      @(posedge clk_i); #1;
      s_rvalid = 0;
      rand_payload();
      txn(1, 1, 0, 1, $urandom, 9, 0, 0);
      rand_payload();
      txn(1, 1, 1, 2, $urandom, 9, 0, 0);

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         r   = $urandom_range(1, 3);
         h   = $urandom_range(0, 3);
         sel = $urandom_range(0, 9);
         rk  = (sel < 7) ? $urandom_range(1, 4) : (sel == 7) ? TO : (sel == 8) ? TO + 1 : TO + 3;
         rand_payload();
         txn(r[0], r[1], h, rk, $urandom, $urandom_range(1, 4), 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end
endmodule
